tagged_rr_mux: RTL and testbench

Packet-aware round-robin arbiter that shares one downstream `tagged_i` stream between `NUM_INPUTS` upstream `data_i` producers. Each accepted beat is tagged with the index of the input it came from. Once a packet starts, its grant is held until the `last` beat so packets never interleave. The block sits in front of shared datapath consumers (serialisers, DMA writers) and replaces ad-hoc muxing of per-source streams.

---
 rtl/tagged_rr_mux_if.sv | 32 +++
 rtl/tagged_rr_mux.sv | 162 ++++++++++++++++
 tb/tb_tagged_rr_mux.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tagged_rr_mux_if.sv
// rtl/tagged_rr_mux_if.sv - payload package and stream interfaces used by tagged_rr_mux
package tagged_rr_mux_pkg;
  typedef logic [31:0] data32_t;
endpackage

interface data_i #(
  parameter type data_t = tagged_rr_mux_pkg::data32_t
);
  data_t data;
  logic  keep;
  logic  last;
  logic  valid;
  logic  ready;

  modport s (input data, keep, last, valid, output ready);
  modport m (output data, keep, last, valid, input ready);
endinterface

interface tagged_i #(
  parameter type data_t    = tagged_rr_mux_pkg::data32_t,
  parameter int  TAG_WIDTH = 2
);
  data_t                data;
  logic [TAG_WIDTH-1:0] tag;
  logic                 keep;
  logic                 last;
  logic                 valid;
  logic                 ready;

  modport m (output data, tag, keep, last, valid, input ready);
  modport s (input data, tag, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_rr_mux.sv
// rtl/tagged_rr_mux.sv - packet-aware round-robin stream merger tagging each beat with its source
// Define TAGGED_RR_MUX_KEEP_FILTER_EN to swallow keep=0 beats that do not end a packet.
module tagged_rr_mux #(
  parameter int  NUM_INPUTS = 4,
  parameter type data_t     = tagged_rr_mux_pkg::data32_t,
  parameter int  TAG_WIDTH  = $clog2(NUM_INPUTS)
) (
  input logic clk,
  input logic rst,
  data_i.s    in [NUM_INPUTS],
  tagged_i.m  out
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   idx_ext_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  data_t                 in_data [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS-1:0] in_keep;
  logic [NUM_INPUTS-1:0] in_last;
  logic [NUM_INPUTS-1:0] in_ready;

  state_t               state_q, state_d;
  idx_t                 ptr_q, ptr_d;
  idx_t                 lock_idx_q, lock_idx_d;
  data_t                data_q, data_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;

  logic     win_found;
  idx_t     win_idx;
  idx_ext_t cand;
  idx_t     grant_idx;
  logic     grant_en;
  logic     can_load;
  logic     accept;
  logic     drop;
  data_t    beat_data;
  logic     beat_keep;
  logic     beat_last;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign in_data[i]  = in[i].data;
    assign in_valid[i] = in[i].valid;
    assign in_keep[i]  = in[i].keep;
    assign in_last[i]  = in[i].last;
    assign in[i].ready = in_ready[i];
  end

  // First valid input at or after ptr, wrapping modulo NUM_INPUTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, ptr_q} + idx_ext_t'(k);
      if (cand >= idx_ext_t'(NUM_INPUTS)) begin
        cand = cand - idx_ext_t'(NUM_INPUTS);
      end
      if (!win_found && in_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // While idle nothing is committed: the winner is re-evaluated every stalled cycle.
  always_comb begin
    can_load = !valid_q || out.ready;
    if (state_q == LOCKED) begin
      grant_idx = lock_idx_q;
      grant_en  = 1'b1;
    end else begin
      grant_idx = win_idx;
      grant_en  = win_found;
    end
    in_ready = '0;
    if (grant_en && can_load && !rst) begin
      in_ready[grant_idx] = 1'b1;
    end
    accept    = in_ready[grant_idx] && in_valid[grant_idx];
    beat_data = in_data[grant_idx];
    beat_keep = in_keep[grant_idx];
    beat_last = in_last[grant_idx];
  end

`ifdef TAGGED_RR_MUX_KEEP_FILTER_EN
  assign drop = !beat_keep && !beat_last;
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    data_d     = data_q;
    tag_d      = tag_q;
    keep_d     = keep_q;
    last_d     = last_q;
    valid_d    = valid_q;

    if (accept && !drop) begin
      valid_d = 1'b1;
      data_d  = beat_data;
      tag_d   = TAG_WIDTH'(grant_idx);
      keep_d  = beat_keep;
      last_d  = beat_last;
    end else if (out.ready) begin
      valid_d = 1'b0;
    end

    // Filtered beats still advance the packet lock.
    if (accept) begin
      if (beat_last) begin
        state_d = IDLE;
        ptr_d   = (grant_idx == idx_t'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
      end else if (state_q == IDLE) begin
        state_d    = LOCKED;
        lock_idx_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      keep_q     <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign out.data  = data_q;
  assign out.tag   = tag_q;
  assign out.keep  = keep_q;
  assign out.last  = last_q;
  assign out.valid = valid_q;

endmodule

// File: tb/tb_tagged_rr_mux.sv
// tb/tb_tagged_rr_mux.sv - randomized scoreboard bench for tagged_rr_mux
module tb_tagged_rr_mux;
  import tagged_rr_mux_pkg::*;

  localparam int N  = 4;
  localparam int TW = 3;
`ifdef TAGGED_RR_MUX_KEEP_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic          keep;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_i   #(.data_t(data32_t))                 in_if [N] ();
  tagged_i #(.data_t(data32_t), .TAG_WIDTH(TW)) out_if ();

  logic [31:0]  tb_data [N];
  logic [N-1:0] tb_valid = '0;
  logic [N-1:0] tb_keep  = '0;
  logic [N-1:0] tb_last  = '0;
  logic [N-1:0] tb_ready;
  logic         out_ready = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_if
    assign in_if[i].data  = tb_data[i];
    assign in_if[i].valid = tb_valid[i];
    assign in_if[i].keep  = tb_keep[i];
    assign in_if[i].last  = tb_last[i];
    assign tb_ready[i]    = in_if[i].ready;
  end
  assign out_if.ready = out_ready;

  tagged_rr_mux #(.NUM_INPUTS(N), .data_t(data32_t), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in_if),
    .out (out_if)
  );

  int           checks    = 0;
  int           errors    = 0;
  int           out_beats = 0;
  int           cyc       = 0;
  int           ready_mode = 0;
  bit           gap_mode   = 1'b0;
  bit           rst_req    = 1'b1;
  beat_t        pend [N][$];
  exp_t         sb [$];
  logic [N-1:0] held = '0;
  int           m_owner = -1;
  int           m_next  = 0;
  bit           m_full  = 1'b0;

  // Monitor: compares each handshaken output beat against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        checks++;
        if (out_if.valid !== 1'b0 || out_if.data !== 32'h0 || out_if.tag !== '0 ||
            out_if.keep !== 1'b0 || out_if.last !== 1'b0) begin
          errors++;
          $display("FAIL reset_out: valid=%0b data=%h tag=%0d keep=%0b last=%0b, required all 0",
                   out_if.valid, out_if.data, out_if.tag, out_if.keep, out_if.last);
        end
      end else begin
        checks++;
        if (out_if.valid !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL out_valid cyc=%0d: got %0b required %0b", cyc, out_if.valid, sb.size() != 0);
        end
        if (out_if.valid === 1'b1 && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          out_beats++;
          checks++;
          if (out_if.data !== e.data || out_if.tag !== e.tag || out_if.keep !== e.keep ||
              out_if.last !== e.last) begin
            errors++;
            $display("FAIL out_beat cyc=%0d: got data=%h tag=%0d keep=%0b last=%0b required data=%h tag=%0d keep=%0b last=%0b",
                     cyc, out_if.data, out_if.tag, out_if.keep, out_if.last, e.data, e.tag, e.keep, e.last);
          end
        end
      end
    end
  end

  // Reference arbiter: packet ownership plus a round-robin start point.
  task automatic model();
    int           g;
    bit           can_load;
    bit           drop;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    exp_t         e;
    g        = -1;
    exp_rdy  = '0;
    can_load = !m_full || out_ready;
    if (!rst) begin
      if (m_owner >= 0) g = m_owner;
      else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && tb_valid[(m_next + k) % N]) g = (m_next + k) % N;
        end
      end
      if (g >= 0 && can_load) exp_rdy[g] = 1'b1;
    end
    checks++;
    if (tb_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready cyc=%0d: got %b required %b", cyc, tb_ready, exp_rdy);
    end
    held = tb_valid;
    if (g >= 0 && exp_rdy[g] && tb_valid[g]) begin
      b       = pend[g].pop_front();
      held[g] = 1'b0;
      drop    = FILTER && !b.keep && !b.last;
      if (!drop) begin
        e.data = b.data;
        e.tag  = TW'(g);
        e.keep = b.keep;
        e.last = b.last;
        sb.push_back(e);
      end
      if (b.last) begin
        m_owner = -1;
        m_next  = (g + 1) % N;
      end else begin
        m_owner = g;
      end
      m_full = !drop || (m_full && !out_ready);
    end else begin
      m_full = m_full && !out_ready;
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = rst_req;
    if (rst_req) begin
      sb.delete();
      m_owner = -1;
      m_next  = 0;
      m_full  = 1'b0;
      held    = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (!held[i]) begin
        tb_valid[i] = (pend[i].size() != 0) && (!gap_mode || $urandom_range(0, 3) != 0);
      end
      if (pend[i].size() != 0) begin
        tb_data[i] = pend[i][0].data;
        tb_keep[i] = pend[i][0].keep;
        tb_last[i] = pend[i][0].last;
      end else begin
        tb_data[i] = $urandom;
        tb_keep[i] = 1'($urandom_range(0, 1));
        tb_last[i] = 1'($urandom_range(0, 1));
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = (cyc % 2 == 0);
    endcase
    #2;
    model();
    cyc++;
  endtask

  function automatic bit busy();
    bit r;
    r = (sb.size() != 0);
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, max);
    end
  endtask

  task automatic push_pkt(input int src, input int len, input logic [31:0] base, input logic [3:0] keeps);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = base + 32'(j);
      b.keep = keeps[j];
      b.last = (j == len - 1);
      pend[src].push_back(b);
    end
  endtask

  initial begin
    int len;
    #1 rst = 1'b1;

    rst_req = 1'b1;
    repeat (10) step();
    rst_req = 1'b0;
    repeat (10) step();

    for (int i = 0; i < N; i++) push_pkt(i, 1, 32'hA0 + 32'(i), 4'hF);
    run_idle("one_beat_each", 20);

    push_pkt(1, 3, 32'hB0, 4'hF);
    step();
    push_pkt(2, 1, 32'hC0, 4'hF);
    run_idle("lock_hold", 20);

    ready_mode = 2;
    push_pkt(3, 4, 32'hD0, 4'hF);
    run_idle("out_stall", 30);
    ready_mode = 0;

    push_pkt(0, 4, 32'hE0, 4'hF);
    step();
    step();
    rst_req = 1'b1;
    pend[0].delete();
    push_pkt(2, 2, 32'hF0, 4'hF);
    repeat (3) step();
    rst_req = 1'b0;
    run_idle("post_reset", 20);

    out_beats = 0;
    push_pkt(0, 3, 32'h50, 4'b0101);
    run_idle("keep_filter", 20);
    checks++;
    if (out_beats != (FILTER ? 2 : 3)) begin
      errors++;
      $display("FAIL keep_beats: got %0d beats required %0d", out_beats, FILTER ? 2 : 3);
    end

    ready_mode = 1;
    gap_mode   = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          push_pkt(i, len, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      step();
    end
    run_idle("random_drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
